// File: rtl/dm_pkg.sv
// Shared types for the wait-state data memory.
//   state_e : controller states (IDLE / ACCESS / DUMP)
//   op_e    : operation latched at request acceptance
//   LAT_W   : width of the latency down-counter (LATENCY up to 255)
package dm_pkg;

  localparam int unsigned LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DUMP   = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dm_array.sv
// Single-ported storage array, DATA_W x 2**ADDR_W, no reset.
// Ports:
//   clk     : clock, read and write both on the rising edge
//   addr_i  : word address
//   we_i    : write enable, writes wdata_i to mem[addr_i]
//   wdata_i : write data
//   rdata_o : registered read data, mem[addr_i] as of the last edge (read-old)
module dm_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_wait.sv
// Data memory with fixed access latency, request/ready handshake and a
// hardware dump sequencer that streams every location out on a port.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   addr, re, we       : access request (level), sampled only in IDLE
//   wrt_data           : write data, latched at acceptance
//   rd_data            : read data, holds until the next read completes
//   rdy                : one-cycle pulse, access complete
//   busy               : access or dump in progress
//   err                : one-cycle pulse, re and we both high in IDLE
//   dump_req           : start a full-memory dump
//   dump_valid/addr/data : dump stream, one word per cycle
//   dump_done          : one-cycle pulse after the last dump word
module dm_wait
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              busy,
  output logic              err,
  input  logic              dump_req,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                dump_done_q, dump_done_d;

  logic [ADDR_W-1:0]   arr_addr_c;
  logic                arr_we_c;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_rdata;

  // A write in flight when reset hits is abandoned, never committed.
  assign arr_we = arr_we_c & ~rst;

  dm_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .addr_i  (arr_addr_c),
    .we_i    (arr_we),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Next-state, datapath and array port control.
  // The array read is registered, so its address is always issued one edge
  // ahead of the edge that consumes arr_rdata: the request address at
  // acceptance, the latched address during ACCESS, ptr+1 during DUMP.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    rd_data_d    = rd_data_q;
    rdy_d        = 1'b0;
    busy_d       = busy_q;
    err_d        = 1'b0;
    dump_valid_d = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_done_d  = 1'b0;
    arr_addr_c   = addr;
    arr_we_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (re ^ we) begin
          op_d    = we ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wrt_data;
          cnt_d   = LAT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end else if (re & we) begin
          err_d = 1'b1;
        end else if (dump_req) begin
          ptr_d      = '0;
          busy_d     = 1'b1;
          arr_addr_c = '0;
          state_d    = DUMP;
        end
      end

      ACCESS: begin
        arr_addr_c = addr_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          if (op_q == OP_WR) begin
            arr_we_c = 1'b1;
          end else begin
            rd_data_d = arr_rdata;
          end
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      DUMP: begin
        arr_addr_c = ADDR_W'(ptr_q + PTR_W'(1));
        // ptr is one bit wider than the address so DEPTH is a clean terminal count.
        if (ptr_q == PTR_W'(DEPTH)) begin
          dump_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          dump_valid_d = 1'b1;
          dump_addr_d  = ADDR_W'(ptr_q);
          dump_data_d  = arr_rdata;
          ptr_d        = ptr_q + PTR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_RD;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      rd_data_q    <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      rd_data_q    <= rd_data_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_dm_wait.sv
// Self-checking bench for dm_wait.
//   u_a : 16-bit address, LATENCY=4  (handshake, table vectors, random, reset)
//   u_b : 4-bit address,  LATENCY=1  (full dump, reset mid-dump)
//   u_c : 16-bit address, LATENCY=1  (top-address boundary)
module tb_dm_wait;

  localparam int A_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_rst, a_re, a_we, a_dreq;
  logic [15:0] a_addr, a_wd;
  logic [15:0] a_rd, a_da, a_dd;
  logic        a_rdy, a_busy, a_err, a_dv, a_done;

  dm_wait #(.DATA_W(16), .ADDR_W(16), .LATENCY(A_LAT)) u_a (
    .clk(clk), .rst(a_rst), .addr(a_addr), .re(a_re), .we(a_we), .wrt_data(a_wd),
    .rd_data(a_rd), .rdy(a_rdy), .busy(a_busy), .err(a_err), .dump_req(a_dreq),
    .dump_valid(a_dv), .dump_addr(a_da), .dump_data(a_dd), .dump_done(a_done)
  );

  // ---------------- instance B ----------------
  logic        b_rst, b_re, b_we, b_dreq;
  logic [3:0]  b_addr, b_da;
  logic [15:0] b_wd, b_rd, b_dd;
  logic        b_rdy, b_busy, b_err, b_dv, b_done;

  dm_wait #(.DATA_W(16), .ADDR_W(4), .LATENCY(1)) u_b (
    .clk(clk), .rst(b_rst), .addr(b_addr), .re(b_re), .we(b_we), .wrt_data(b_wd),
    .rd_data(b_rd), .rdy(b_rdy), .busy(b_busy), .err(b_err), .dump_req(b_dreq),
    .dump_valid(b_dv), .dump_addr(b_da), .dump_data(b_dd), .dump_done(b_done)
  );

  // ---------------- instance C ----------------
  logic        c_rst, c_re, c_we, c_dreq;
  logic [15:0] c_addr, c_wd, c_rd, c_da, c_dd;
  logic        c_rdy, c_busy, c_err, c_dv, c_done;

  dm_wait #(.DATA_W(16), .ADDR_W(16), .LATENCY(1)) u_c (
    .clk(clk), .rst(c_rst), .addr(c_addr), .re(c_re), .we(c_we), .wrt_data(c_wd),
    .rd_data(c_rd), .rdy(c_rdy), .busy(c_busy), .err(c_err), .dump_req(c_dreq),
    .dump_valid(c_dv), .dump_addr(c_da), .dump_data(c_dd), .dump_done(c_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on A; inputs are dropped after the request edge and addr/data
  // are scrambled while waiting, which must not affect the result.
  // lat = cycles from request edge to the rdy cycle, -1 if no rdy.
  task automatic a_access(input logic r, input logic w, input logic [15:0] ad,
                          input logic [15:0] d, input logic dq,
                          output int lat, output logic [15:0] rd,
                          output logic e, output logic side_ok);
    a_re = r; a_we = w; a_addr = ad; a_wd = d; a_dreq = dq;
    tick();
    e       = a_err;
    side_ok = (a_busy == (r ^ w));
    a_re = 1'b0; a_we = 1'b0; a_dreq = 1'b0;
    lat = -1;
    rd  = a_rd;
    for (int n = 1; n <= A_LAT + 6; n++) begin
      a_addr = 16'($urandom);
      a_wd   = 16'($urandom);
      tick();
      if (a_err || a_dv || a_done) side_ok = 1'b0;
      if (a_rdy) begin
        if (lat < 0) begin
          lat = n;
          rd  = a_rd;
          if (a_busy) side_ok = 1'b0;
        end else begin
          side_ok = 1'b0;
        end
      end else if (lat < 0 && (r ^ w) && !a_busy) begin
        side_ok = 1'b0;
      end else if (lat >= 0 && a_busy) begin
        side_ok = 1'b0;
      end
    end
  endtask

  task automatic b_write(input logic [3:0] ad, input logic [15:0] d);
    b_we = 1'b1; b_addr = ad; b_wd = d;
    tick();
    b_we = 1'b0;
    tick();
  endtask

  task automatic b_read(input string name, input logic [3:0] ad, input logic [15:0] exp);
    b_re = 1'b1; b_addr = ad;
    tick();
    b_re = 1'b0;
    tick();
    check(name, {b_rdy, b_rd}, {1'b1, exp});
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] addr;
    logic [15:0] data;
    int          lat;
    logic [15:0] rd;   // expected read data, used on read rows only
    logic        e;
  } vec_t;

  vec_t vt[10];

  // Reference memory for the random phase.
  logic [15:0] model_mem [logic [15:0]];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int          lat;
    logic [15:0] rd, last_rd, exp_rd;
    logic        e, ok, seen;
    int          idx;
    logic [15:0] pool [6];

    a_rst = 1'b1; a_re = 1'b0; a_we = 1'b0; a_dreq = 1'b0; a_addr = '0; a_wd = '0;
    b_rst = 1'b1; b_re = 1'b0; b_we = 1'b0; b_dreq = 1'b0; b_addr = '0; b_wd = '0;
    c_rst = 1'b1; c_re = 1'b0; c_we = 1'b0; c_dreq = 1'b0; c_addr = '0; c_wd = '0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // ---- reset state ----
    check("rst rd_data",    64'(a_rd),   64'h0);
    check("rst rdy",        64'(a_rdy),  64'h0);
    check("rst busy",       64'(a_busy), 64'h0);
    check("rst err",        64'(a_err),  64'h0);
    check("rst dump_valid", 64'(a_dv),   64'h0);
    check("rst dump_addr",  64'(a_da),   64'h0);
    check("rst dump_data",  64'(a_dd),   64'h0);
    check("rst dump_done",  64'(a_done), 64'h0);
    check("rst B outputs", {b_rd, b_rdy, b_busy, b_err, b_dv, b_da, b_dd, b_done}, '0);

    // ---- table-driven vectors on A ----
    vt[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, A_LAT, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, A_LAT, 16'hBEEF, 1'b0};
    vt[2] = '{1'b0, 1'b1, 16'h0001, 16'h1111, A_LAT, 16'h0000, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'h0002, 16'h2222, A_LAT, 16'h0000, 1'b0};
    vt[4] = '{1'b0, 1'b1, 16'h0003, 16'h3333, A_LAT, 16'h0000, 1'b0};
    vt[5] = '{1'b1, 1'b1, 16'h0010, 16'h0BAD, -1,    16'h0000, 1'b1};
    vt[6] = '{1'b1, 1'b0, 16'h0010, 16'h0000, A_LAT, 16'hBEEF, 1'b0};
    vt[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h7E57, A_LAT, 16'h0000, 1'b0};
    vt[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, A_LAT, 16'h7E57, 1'b0};
    vt[9] = '{1'b1, 1'b0, 16'h0002, 16'h0000, A_LAT, 16'h2222, 1'b0};

    last_rd = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      a_access(vt[i].r, vt[i].w, vt[i].addr, vt[i].data, 1'b1, lat, rd, e, ok);
      exp_rd = (vt[i].r && !vt[i].w) ? vt[i].rd : last_rd;
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].lat));
      check($sformatf("vec%0d rd_data", i), 64'(rd),  64'(exp_rd));
      check($sformatf("vec%0d err", i),     64'(e),   64'(vt[i].e));
      check($sformatf("vec%0d busy/side", i), 64'(ok), 64'h1);
      last_rd = exp_rd;
    end

    // ---- back-to-back reads with re held ----
    // Each rdy cycle is IDLE, so accepts occur every LATENCY+1 edges and the
    // i-th rdy lands i*(LATENCY+1)+LATENCY edges after the first accept.
    a_re = 1'b1; a_addr = 16'h0001;
    tick();
    idx = 0;
    ok  = 1'b1;
    for (int t = 1; t <= 3 * (A_LAT + 1) + 4; t++) begin
      tick();
      if (idx < 3 && (a_busy == a_rdy)) ok = 1'b0;
      if (a_rdy) begin
        check($sformatf("b2b%0d cycle", idx), 64'(t), 64'(idx * (A_LAT + 1) + A_LAT));
        check($sformatf("b2b%0d rd_data", idx), 64'(a_rd), 64'(16'(32'h1111 * (idx + 1))));
        idx++;
        if (idx < 3) a_addr = 16'(idx + 1);
        else a_re = 1'b0;
      end
    end
    a_re = 1'b0;
    check("b2b rdy count", 64'(idx), 64'd3);
    check("b2b busy between", 64'(ok), 64'h1);
    last_rd = 16'h3333;

    // ---- randomized traffic against the reference memory ----
    for (int i = 0; i < 6; i++) begin
      pool[i] = 16'($urandom);
      model_mem[pool[i]] = 16'($urandom);
      a_access(1'b0, 1'b1, pool[i], model_mem[pool[i]], 1'b0, lat, rd, e, ok);
      check($sformatf("rnd init%0d latency", i), 64'(lat), 64'(A_LAT));
    end
    for (int i = 0; i < 30; i++) begin
      int          kind;
      logic [15:0] ad, d;
      logic        r, w;
      kind = int'($urandom_range(0, 9));
      ad   = pool[$urandom_range(0, 5)];
      d    = 16'($urandom);
      r    = (kind == 0) || (kind >= 5);
      w    = (kind <= 4);
      a_access(r, w, ad, d, 1'($urandom), lat, rd, e, ok);
      if (r && w) begin
        check($sformatf("rnd%0d conflict err", i), {32'(lat), 16'(rd), 8'(e)},
              {32'hFFFF_FFFF, last_rd, 8'h01});
      end else if (w) begin
        model_mem[ad] = d;
        check($sformatf("rnd%0d write", i), {32'(lat), 16'(rd), 8'(e)},
              {32'(A_LAT), last_rd, 8'h00});
      end else begin
        last_rd = model_mem[ad];
        check($sformatf("rnd%0d read", i), {32'(lat), 16'(rd), 8'(e)},
              {32'(A_LAT), last_rd, 8'h00});
      end
      check($sformatf("rnd%0d side", i), 64'(ok), 64'h1);
    end

    // ---- reset two cycles after a write is accepted ----
    a_access(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, lat, rd, e, ok);
    check("rstmid prewrite latency", 64'(lat), 64'(A_LAT));
    a_we = 1'b1; a_addr = 16'h0020; a_wd = 16'hDEAD;
    tick();
    a_we = 1'b0;
    tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("rstmid outputs", {a_rd, a_rdy, a_busy, a_err, a_dv, a_da, a_dd, a_done}, '0);
    seen = 1'b0;
    for (int i = 0; i < A_LAT + 4; i++) begin
      tick();
      if (a_rdy || a_busy) seen = 1'b1;
    end
    check("rstmid no rdy", 64'(seen), 64'h0);
    a_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, rd, e, ok);
    check("rstmid readback", {32'(lat), 16'(rd)}, {32'(A_LAT), 16'h1234});

    // ---- full dump on B ----
    for (int i = 0; i < 16; i++) b_write(4'(i), 16'(i * 3));
    b_dreq = 1'b1;
    tick();
    b_dreq = 1'b0;
    check("dump entry", {b_busy, b_dv, b_done}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 16; i++) begin
      b_re = 1'($urandom); b_we = 1'($urandom); b_dreq = 1'($urandom);
      b_addr = 4'($urandom); b_wd = 16'($urandom);
      tick();
      check($sformatf("dump word%0d", i), {b_dv, b_busy, b_done, b_da, b_dd},
            {1'b1, 1'b1, 1'b0, 4'(i), 16'(i * 3)});
    end
    b_re = 1'b0; b_we = 1'b0; b_dreq = 1'b0;
    tick();
    check("dump done", {b_dv, b_busy, b_done}, {1'b0, 1'b0, 1'b1});
    tick();
    check("dump done pulse", {b_dv, b_busy, b_done}, 3'b000);
    b_read("dump mem intact", 4'd9, 16'd27);

    // ---- reset mid-dump on B ----
    b_dreq = 1'b1;
    tick();
    b_dreq = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("dump rst outputs", {b_rd, b_rdy, b_busy, b_err, b_dv, b_da, b_dd, b_done}, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_done || b_dv) seen = 1'b1;
    end
    check("dump rst no done", 64'(seen), 64'h0);
    b_read("dump rst readback", 4'd15, 16'd45);

    // ---- LATENCY=1 at the top address on C ----
    c_we = 1'b1; c_addr = 16'hFFFF; c_wd = 16'hA5A5;
    tick();
    c_we = 1'b0; c_wd = 16'h0000; c_addr = 16'h0000;
    check("lat1 write accept", {c_busy, c_rdy}, 2'b10);
    tick();
    check("lat1 write rdy", {c_busy, c_rdy}, 2'b01);
    c_re = 1'b1; c_addr = 16'hFFFF;
    tick();
    c_re = 1'b0; c_addr = 16'h0000;
    check("lat1 read accept", {c_busy, c_rdy}, 2'b10);
    tick();
    check("lat1 read rdy", {c_busy, c_rdy, c_rd}, {2'b01, 16'hA5A5});
    tick();
    check("lat1 rdy pulse", {c_busy, c_rdy, c_rd}, {2'b00, 16'hA5A5});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
